// File: rtl/touch_adc_ctrl_pkg.sv
// Shared types and constants for the resistive-touch ADC controller.
// TOUCH_AVG_EN selects four conversions per axis instead of one.
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV_X,
        CONV_Y,
        CHECK,
        GAP
    } state_t;

    // Sub-steps of one conversion slot: launch, wait for done, cs_n-high tail
    typedef enum logic [1:0] {
        PH_START,
        PH_WAIT,
        PH_TAIL
    } phase_t;

    // dclk rising-edge numbers within one 24-edge conversion
    localparam logic [4:0] CMD_LAST   = 5'd8;
    localparam logic [4:0] DATA_FIRST = 5'd10;
    localparam logic [4:0] DATA_LAST  = 5'd21;
    localparam logic [4:0] CONV_EDGES = 5'd24;

    localparam logic [7:0] X_CMD_DEF = 8'h92;
    localparam logic [7:0] Y_CMD_DEF = 8'hD2;

`ifdef TOUCH_AVG_EN
    localparam logic [1:0] LAST_REP = 2'd3;
`else
    localparam logic [1:0] LAST_REP = 2'd0;
`endif

endpackage

// File: rtl/touch_adc_ctrl_if.sv
// Touch ADC serial link plus the coordinate interface towards the touch UI.
interface touch_adc_ctrl_if;

    logic       penirq_n;
    logic       adc_dout;
    logic       adc_cs_n;
    logic       adc_dclk;
    logic       adc_din;
    logic [7:0] x_coord;
    logic [9:0] y_coord;
    logic       new_coord;
    logic       transmit_en;

    modport master (
        input  penirq_n, adc_dout,
        output adc_cs_n, adc_dclk, adc_din,
        output x_coord, y_coord, new_coord, transmit_en
    );

    modport slave (
        output penirq_n, adc_dout,
        input  adc_cs_n, adc_dclk, adc_din,
        input  x_coord, y_coord, new_coord, transmit_en
    );

endinterface

// File: rtl/touch_adc_ctrl_spi_xfer.sv
// One 24-edge ADC conversion: dclk divider, command shift-out, 12-bit capture.
module touch_spi_xfer
    import touch_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic        dout,
    output logic        cs_n,
    output logic        dclk,
    output logic        din,
    output logic        done,
    output logic [11:0] data
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       edge_cnt;
    logic [4:0]       edge_nxt;
    logic [7:0]       cmd_sr;
    logic             tick;

    assign tick     = busy && (div_cnt == DIV_LAST);
    assign edge_nxt = edge_cnt + 5'd1;

    // Divider, dclk toggle, din on falling edges, dout capture on rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cmd_sr   <= '0;
            cs_n     <= 1'b1;
            dclk     <= 1'b0;
            din      <= 1'b0;
            done     <= 1'b0;
            data     <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    // Bit 7 goes out now, half a dclk period ahead of rising edge 1
                    busy     <= 1'b1;
                    cs_n     <= 1'b0;
                    din      <= cmd[7];
                    cmd_sr   <= {cmd[6:0], 1'b0};
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                end
            end else if (tick) begin
                div_cnt <= '0;
                dclk    <= ~dclk;
                if (!dclk) begin
                    edge_cnt <= edge_nxt;
                    if (edge_nxt >= DATA_FIRST && edge_nxt <= DATA_LAST) begin
                        data <= {data[10:0], dout};
                    end
                end else if (edge_cnt == CONV_EDGES) begin
                    busy <= 1'b0;
                    cs_n <= 1'b1;
                    done <= 1'b1;
                end else if (edge_cnt < CMD_LAST) begin
                    din    <= cmd_sr[7];
                    cmd_sr <= {cmd_sr[6:0], 1'b0};
                end else begin
                    din <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/touch_adc_ctrl.sv
// SPI master for an AD7843-class touch ADC: pen detect, X/Y frames, scaled
// coordinate publish. Define TOUCH_AVG_EN to average four samples per axis.
module touch_adc_ctrl
    import touch_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [7:0]  X_CMD      = X_CMD_DEF,
    parameter logic [7:0]  Y_CMD      = Y_CMD_DEF,
    parameter int unsigned PEN_SETTLE = 64,
    parameter int unsigned FRAME_GAP  = 1024
) (
    input  logic              sys_clk,
    input  logic              iRST_n,
    touch_adc_ctrl_if.master  bus
);

    localparam int unsigned TAIL_CYC = 4 * CLK_DIV;
    localparam int unsigned MAX_A    = (FRAME_GAP > PEN_SETTLE) ? FRAME_GAP : PEN_SETTLE;
    localparam int unsigned CNT_MAX  = (MAX_A > TAIL_CYC) ? MAX_A : TAIL_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PEN_SETTLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(FRAME_GAP - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST   = CNT_W'(TAIL_CYC - 1);

    state_t           state, state_nxt;
    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       rep, rep_nxt;
    logic [1:0]       pen_sync, dout_sync;
    logic             pen_n;
    logic             xfer_start, xfer_done;
    logic [7:0]       xfer_cmd;
    logic [11:0]      xfer_data;
    logic             cap_x, cap_y, publish, te_set, te_clr;
    logic [11:0]      raw_x, raw_y;
    logic [7:0]       x_coord;
    logic [9:0]       y_coord;
    logic             new_coord, transmit_en;

    assign pen_n = pen_sync[1];

    // Two-flop synchronisers for the asynchronous ADC inputs
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            pen_sync  <= 2'b11;
            dout_sync <= 2'b00;
        end else begin
            pen_sync  <= {pen_sync[0], bus.penirq_n};
            dout_sync <= {dout_sync[0], bus.adc_dout};
        end
    end

    touch_spi_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk   (sys_clk),
        .rst_n (iRST_n),
        .start (xfer_start),
        .cmd   (xfer_cmd),
        .dout  (dout_sync[1]),
        .cs_n  (bus.adc_cs_n),
        .dclk  (bus.adc_dclk),
        .din   (bus.adc_din),
        .done  (xfer_done),
        .data  (xfer_data)
    );

    // Frame sequencer: next state, sub-phase, counters and event strobes
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        cnt_nxt    = cnt;
        rep_nxt    = rep;
        xfer_start = 1'b0;
        xfer_cmd   = X_CMD;
        cap_x      = 1'b0;
        cap_y      = 1'b0;
        publish    = 1'b0;
        te_set     = 1'b0;
        te_clr     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!pen_n) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (pen_n) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = CONV_X;
                    phase_nxt = PH_START;
                    rep_nxt   = '0;
                    cnt_nxt   = '0;
                    te_set    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CONV_X, CONV_Y: begin
                xfer_cmd = (state == CONV_X) ? X_CMD : Y_CMD;
                case (phase)
                    PH_START: begin
                        xfer_start = 1'b1;
                        phase_nxt  = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (xfer_done) begin
                            cap_x     = (state == CONV_X);
                            cap_y     = (state == CONV_Y);
                            phase_nxt = PH_TAIL;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        // cs_n stays high for two dclk periods between windows
                        if (cnt == TAIL_LAST) begin
                            cnt_nxt   = '0;
                            phase_nxt = PH_START;
                            if (rep == LAST_REP) begin
                                rep_nxt   = '0;
                                state_nxt = (state == CONV_X) ? CONV_Y : CHECK;
                            end else begin
                                rep_nxt = rep + 2'd1;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                endcase
            end
            CHECK: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt = '0;
                    if (!pen_n) begin
                        publish   = 1'b1;
                        state_nxt = GAP;
                    end else begin
                        te_clr    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = CONV_X;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and published outputs
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state       <= IDLE;
            phase       <= PH_START;
            cnt         <= '0;
            rep         <= '0;
            x_coord     <= '0;
            y_coord     <= '0;
            new_coord   <= 1'b0;
            transmit_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            rep       <= rep_nxt;
            new_coord <= publish;
            if (publish) begin
                x_coord <= 8'(raw_x >> 4);
                y_coord <= 10'(raw_y >> 2);
            end
            if (te_set) begin
                transmit_en <= 1'b1;
            end else if (te_clr) begin
                transmit_en <= 1'b0;
            end
        end
    end

`ifdef TOUCH_AVG_EN
    logic [13:0] acc_x, acc_y;

    // Sum four samples per axis; the first sample of each burst reloads the sum
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            acc_x <= '0;
            acc_y <= '0;
        end else begin
            if (cap_x) acc_x <= ((rep == 2'd0) ? 14'd0 : acc_x) + {2'b00, xfer_data};
            if (cap_y) acc_y <= ((rep == 2'd0) ? 14'd0 : acc_y) + {2'b00, xfer_data};
        end
    end

    assign raw_x = 12'(acc_x >> 2);
    assign raw_y = 12'(acc_y >> 2);
`else
    // Hold the raw 12-bit samples until the frame is confirmed in CHECK
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            raw_x <= '0;
            raw_y <= '0;
        end else begin
            if (cap_x) raw_x <= xfer_data;
            if (cap_y) raw_y <= xfer_data;
        end
    end
`endif

    assign bus.x_coord     = x_coord;
    assign bus.y_coord     = y_coord;
    assign bus.new_coord   = new_coord;
    assign bus.transmit_en = transmit_en;

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Directed bench for touch_adc_ctrl with a behavioural AD7843 model.
module tb_touch_adc_ctrl;

`ifdef TOUCH_AVG_EN
    localparam int unsigned REPS = 4;
`else
    localparam int unsigned REPS = 1;
`endif
    localparam int unsigned FRAME_GAP = 1024;
    localparam int unsigned NW        = 128;

    logic sys_clk = 1'b0;
    logic iRST_n  = 1'b0;
    logic pen_n   = 1'b0;
    logic dout_drv = 1'b0;

    touch_adc_ctrl_if bus ();

    assign bus.penirq_n = pen_n;
    assign bus.adc_dout = dout_drv;

    touch_adc_ctrl #(
        .CLK_DIV    (2),
        .X_CMD      (8'h92),
        .Y_CMD      (8'hD2),
        .PEN_SETTLE (64),
        .FRAME_GAP  (FRAME_GAP)
    ) dut (
        .sys_clk (sys_clk),
        .iRST_n  (iRST_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC model: samples din on rising dclk, drives dout right after each rising edge
    logic [11:0]  samp [NW];
    logic [7:0]   cmd_seen [NW];
    int unsigned  edges_seen [NW];
    int unsigned  win_start_cnt = 0;
    int unsigned  win_end_cnt = 0;
    int unsigned  edge_n = 0;
    int unsigned  dclk_total = 0;
    logic [7:0]   cmd_sh = '0;
    logic [11:0]  cur = '0;
    logic         in_win = 1'b0;

    always @(negedge bus.adc_cs_n) begin
        in_win = 1'b1;
        edge_n = 0;
        cmd_sh = '0;
        cur    = samp[win_start_cnt % NW];
        win_start_cnt++;
    end

    always @(posedge bus.adc_dclk) begin
        dclk_total++;
        if (in_win) begin
            edge_n++;
            if (edge_n <= 8) cmd_sh = {cmd_sh[6:0], bus.adc_din};
            if (edge_n == 8 || edge_n == 21) dout_drv = 1'b1;
            else if (edge_n >= 9 && edge_n <= 20) dout_drv = cur[20 - edge_n];
            else dout_drv = 1'b0;
        end
    end

    always @(posedge bus.adc_cs_n) begin
        if (in_win) begin
            cmd_seen[win_end_cnt % NW]   = cmd_sh;
            edges_seen[win_end_cnt % NW] = edge_n;
            win_end_cnt++;
            in_win = 1'b0;
        end
    end

    // Output monitor, sampled 1 time unit after each active edge
    int unsigned cyc = 0, nc_rises = 0, nc_high = 0, te_rises = 0, te_falls = 0;
    int unsigned pulse_cyc [16];
    logic nc_d = 1'b0, te_d = 1'b0;

    always @(posedge sys_clk) begin
        cyc++;
        #1;
        if (bus.new_coord === 1'b1) begin
            nc_high++;
            if (!nc_d) begin
                pulse_cyc[nc_rises % 16] = cyc;
                nc_rises++;
            end
        end
        if (bus.transmit_en === 1'b1 && !te_d) te_rises++;
        if (bus.transmit_en === 1'b0 && te_d) te_falls++;
        nc_d = (bus.new_coord === 1'b1);
        te_d = (bus.transmit_en === 1'b1);
    end

    function automatic logic [11:0] avg_raw(input logic [11:0] base);
        int unsigned s = 0;
        for (int unsigned r = 0; r < REPS; r++) s += 32'(base) + 4 * r;
        return (REPS == 4) ? 12'(s >> 2) : 12'(s);
    endfunction

    function automatic logic [7:0] exp_x(input logic [11:0] base);
        logic [11:0] r = avg_raw(base);
        return r[11:4];
    endfunction

    function automatic logic [9:0] exp_y(input logic [11:0] base);
        logic [11:0] r = avg_raw(base);
        return r[11:2];
    endfunction

    task automatic set_frame(input int unsigned w, input logic [11:0] xb, input logic [11:0] yb);
        for (int unsigned r = 0; r < REPS; r++) begin
            samp[(w + r) % NW]        = xb + 12'(4 * r);
            samp[(w + REPS + r) % NW] = yb + 12'(4 * r);
        end
    endtask

    task automatic wait_pulses(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned t = 0;
        while (nc_rises < n && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        check(tag, 32'(nc_rises >= n), 32'd1);
    endtask

    task automatic wait_te_low(input int unsigned budget, input string tag);
        int unsigned t = 0;
        while (bus.transmit_en !== 1'b0 && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        check(tag, 32'(bus.transmit_en), 32'd0);
    endtask

    task automatic wait_win_start(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned t = 0;
        while (win_start_cnt < n && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        check(tag, 32'(win_start_cnt >= n), 32'd1);
    endtask

    initial begin
        int unsigned base, pr, tf, tr, ws;
        for (int unsigned i = 0; i < NW; i++) samp[i] = '0;

        // Reset held with the pen down: everything quiet
        repeat (10) @(negedge sys_clk);
        check("rst_cs_n",   32'(bus.adc_cs_n), 32'd1);
        check("rst_dclk",   32'(bus.adc_dclk), 32'd0);
        check("rst_din",    32'(bus.adc_din), 32'd0);
        check("rst_te",     32'(bus.transmit_en), 32'd0);
        check("rst_new",    32'(bus.new_coord), 32'd0);
        check("rst_x",      32'(bus.x_coord), 32'd0);
        check("rst_y",      32'(bus.y_coord), 32'd0);
        check("rst_dclk_n", dclk_total, 32'd0);
        pen_n = 1'b1;
        @(negedge sys_clk);
        iRST_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("idle_cs_n", 32'(bus.adc_cs_n), 32'd1);

        // Basic frame, then pen lifted during GAP: next frame runs and is discarded
        set_frame(0, 12'hABC, 12'h8F0);
        set_frame(2 * REPS, 12'h123, 12'h456);
        pen_n = 1'b0;
        wait_pulses(1, 4000, "basic_pulse_wait");
        check("basic_x",     32'(bus.x_coord), 32'(exp_x(12'hABC)));
        check("basic_y",     32'(bus.y_coord), 32'(exp_y(12'h8F0)));
        check("basic_te",    32'(bus.transmit_en), 32'd1);
        check("basic_xcmd",  32'(cmd_seen[0]), 32'h92);
        check("basic_ycmd",  32'(cmd_seen[REPS]), 32'hD2);
        check("basic_xedge", edges_seen[0], 32'd24);
        check("basic_yedge", edges_seen[REPS], 32'd24);
        check("basic_wins",  win_end_cnt, 2 * REPS);
        @(negedge sys_clk);
        check("basic_pulse_w", nc_high, 32'd1);
        pen_n = 1'b1;
        wait_te_low(4000, "release_te_wait");
        check("release_no_pulse", nc_rises, 32'd1);
        check("release_x",    32'(bus.x_coord), 32'(exp_x(12'hABC)));
        check("release_y",    32'(bus.y_coord), 32'(exp_y(12'h8F0)));
        check("release_wins", win_end_cnt, 4 * REPS);

        // Short pen glitch never reaches a conversion
        ws = win_start_cnt;
        tr = te_rises;
        pen_n = 1'b0;
        repeat (40) @(negedge sys_clk);
        pen_n = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("glitch_wins", win_start_cnt, ws);
        check("glitch_te",   te_rises, tr);
        check("glitch_cs_n", 32'(bus.adc_cs_n), 32'd1);

        // Continuous touch: three published frames, then a fourth lifted mid-Y
        base = win_end_cnt;
        pr   = nc_rises;
        tf   = te_falls;
        tr   = te_rises;
        set_frame(base,            12'h111, 12'h222);
        set_frame(base + 2 * REPS, 12'h333, 12'h444);
        set_frame(base + 4 * REPS, 12'h555, 12'h666);
        set_frame(base + 6 * REPS, 12'h777, 12'h888);
        pen_n = 1'b0;
        wait_pulses(pr + 1, 4000, "cont1_wait");
        check("cont1_x", 32'(bus.x_coord), 32'(exp_x(12'h111)));
        check("cont1_y", 32'(bus.y_coord), 32'(exp_y(12'h222)));
        wait_pulses(pr + 2, 4000, "cont2_wait");
        check("cont2_x", 32'(bus.x_coord), 32'(exp_x(12'h333)));
        check("cont2_y", 32'(bus.y_coord), 32'(exp_y(12'h444)));
        check("cont_gap12", 32'((pulse_cyc[(pr + 1) % 16] - pulse_cyc[pr % 16]) >= FRAME_GAP), 32'd1);
        wait_pulses(pr + 3, 4000, "cont3_wait");
        check("cont3_x", 32'(bus.x_coord), 32'(exp_x(12'h555)));
        check("cont3_y", 32'(bus.y_coord), 32'(exp_y(12'h666)));
        check("cont_gap23", 32'((pulse_cyc[(pr + 2) % 16] - pulse_cyc[(pr + 1) % 16]) >= FRAME_GAP), 32'd1);
        check("cont_te_falls", te_falls, tf);
        check("cont_te_rises", te_rises, tr + 1);
        check("cont_te",       32'(bus.transmit_en), 32'd1);

        wait_win_start(base + 6 * REPS + REPS + 1, 4000, "penup_ywin_wait");
        pen_n = 1'b1;
        wait_te_low(4000, "penup_te_wait");
        check("penup_no_pulse", nc_rises, pr + 3);
        check("penup_new",      32'(bus.new_coord), 32'd0);
        check("penup_x",        32'(bus.x_coord), 32'(exp_x(12'h555)));
        check("penup_y",        32'(bus.y_coord), 32'(exp_y(12'h666)));
        check("penup_wins",     win_end_cnt, base + 8 * REPS);
        check("penup_last_edge", edges_seen[(base + 8 * REPS - 1) % NW], 32'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
